// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator sequencing controller.
//   acc_state_e : controller FSM states (IDLE -> GRANT -> ADD)
//   ACC_WIDTH   : default operand/accumulator width
//   ACC_CNT_W   : default operation-counter width
//   SAT_MAX/MIN : signed clamp limits for the default width, used when
//                 the ACC_SATURATE_EN build option is defined
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ADD   = 2'd2
    } acc_state_e;

    localparam int unsigned ACC_WIDTH = 8;
    localparam int unsigned ACC_CNT_W = 8;

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Requester-side handshake bundle for acc_seq_ctrl.
//   req_valid [1:0]  : requester i has an operand pending
//   req_data0/1      : operands from requester 0 / 1
//   req_ready [1:0]  : one-hot accept, transfer when valid[i] & ready[i]
// Modports: master = requesters, slave = controller.
interface acc_seq_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [1:0]       req_ready;

    modport master (
        output req_valid,
        output req_data0,
        output req_data1,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data0,
        input  req_data1,
        output req_ready
    );
endinterface

// File: rtl/acc_rr_arbiter.sv
// Two-way round-robin arbiter, purely combinational.
//   req_valid [1:0] : pending requests
//   ptr             : last requester served (loses a tie)
//   upd_en/upd_id   : pointer update request from the parent
//   gnt_any         : at least one request pending
//   gnt_id          : chosen requester
//   ptr_nxt         : next pointer value; the register lives in the parent
module acc_rr_arbiter (
    input  logic [1:0] req_valid,
    input  logic       ptr,
    input  logic       upd_en,
    input  logic       upd_id,
    output logic       gnt_any,
    output logic       gnt_id,
    output logic       ptr_nxt
);

    always_comb begin
        gnt_any = |req_valid;
        gnt_id  = 1'b0;
        unique case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~ptr;   // strict alternation on contention
            default: gnt_id = 1'b0;
        endcase
    end

    always_comb begin
        ptr_nxt = upd_en ? upd_id : ptr;
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequencing/arbitration controller for a shared accumulator.
// Two requesters offer operands over valid/ready; a round-robin arbiter
// picks one, the FSM captures it in GRANT and adds it into the sum in ADD.
//   Clock, Resetn      : clock, synchronous active-low reset
//   req (slave)        : requester handshake bundle
//   clr                : synchronous clear of sum, flags and counter
//   sum, carry         : accumulator value and carry-out of the last add
//   overflow           : sticky signed overflow
//   busy               : FSM not in IDLE
//   grant_id           : current / last granted requester
//   op_count           : completed adds, wrapping
// Build option: ACC_SATURATE_EN clamps the sum on signed overflow.
module acc_seq_ctrl
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = ACC_WIDTH,
    parameter int unsigned CNT_W = ACC_CNT_W
) (
    input  logic               Clock,
    input  logic               Resetn,
    acc_seq_ctrl_if.slave      req,
    input  logic               clr,
    output logic [WIDTH-1:0]   sum,
    output logic               carry,
    output logic               overflow,
    output logic               busy,
    output logic               grant_id,
    output logic [CNT_W-1:0]   op_count
);

    localparam int unsigned MSB = WIDTH - 1;
`ifdef ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gid_q, gid_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             busy_q, busy_d;

    logic             arb_any;
    logic             arb_gnt;
    logic             grant_valid;
    logic             accept;
    logic [WIDTH:0]   add_res;
    logic             ovf_now;
    logic [WIDTH-1:0] sum_add;

    assign grant_valid = req.req_valid[gid_q];
    // The handshake only completes in GRANT, and never while clr is high.
    assign accept      = (state_q == GRANT) && grant_valid && !clr;

    acc_rr_arbiter u_arb (
        .req_valid (req.req_valid),
        .ptr       (ptr_q),
        .upd_en    (accept),
        .upd_id    (gid_q),
        .gnt_any   (arb_any),
        .gnt_id    (arb_gnt),
        .ptr_nxt   (ptr_d)
    );

    always_comb begin
        req.req_ready = '0;
        if (accept) begin
            req.req_ready = gid_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        add_res = {1'b0, sum_q} + {1'b0, a_q};
        // Operands of equal sign producing a result of the other sign.
        ovf_now = (sum_q[MSB] == a_q[MSB]) && (add_res[MSB] != sum_q[MSB]);
`ifdef ACC_SATURATE_EN
        if (ovf_now) begin
            sum_add = a_q[MSB] ? SAT_LO : SAT_HI;
        end else begin
            sum_add = add_res[WIDTH-1:0];
        end
`else
        sum_add = add_res[WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        gid_d   = gid_q;
        a_d     = a_q;

        if (clr) begin
            state_d = IDLE;
            sum_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gid_d   = arb_gnt;
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    if (grant_valid) begin
                        a_d     = gid_q ? req.req_data1 : req.req_data0;
                        state_d = ADD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADD: begin
                    sum_d   = sum_add;
                    carry_d = add_res[WIDTH];
                    ovf_d   = ovf_q | ovf_now;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            gid_q   <= 1'b0;
            ptr_q   <= 1'b1;   // requester 0 wins the first tie
            a_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
        end
    end

    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;
    assign op_count = cnt_q;

endmodule
